cl_ocl_axil_regs: RTL

AXI-Lite slave register file for the PCIe AppPF BAR0 (OCL) path, sitting directly downstream of the OCL AXI-L register slice in the CL top. It consumes single-beat reads and writes, and provides the hello-world, virtual-LED and scratch registers. It drives the VLED status output to the shell. It supports one outstanding write and one outstanding read, with write and read channels running independently.

---
 rtl/cl_ocl_axil_regs_pkg.sv | 38 +++
 rtl/cl_ocl_cycle_cnt.sv | 37 +++
 rtl/cl_ocl_axil_regs.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_ocl_axil_regs_pkg.sv
// ---------------------------------------------------------------------------
// cl_ocl_axil_regs_pkg
// Shared definitions for the OCL (AppPF BAR0) AXI-Lite register file:
//   - register byte addresses (decode uses addr[31:2])
//   - AXI response codes and the unmapped-read filler word
//   - write / read channel FSM state encodings
//   - byte-strobe merge helper
// ---------------------------------------------------------------------------
package cl_ocl_axil_regs_pkg;

    localparam logic [31:0] HELLO_WORLD = 32'h0000_0500;
    localparam logic [31:0] VLED        = 32'h0000_0504;
    localparam logic [31:0] CNT_LO      = 32'h0000_0508;
    localparam logic [31:0] CNT_HI      = 32'h0000_050C;
    localparam logic [31:0] SCRATCH     = 32'h0000_0510;

    localparam logic [1:0]  OKAY        = 2'b00;
    localparam logic [1:0]  SLVERR      = 2'b10;

    localparam logic [31:0] DEAD_BEEF   = 32'hDEAD_BEEF;

    localparam int          CNT_W       = 64;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wr,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? wr[i*8 +: 8] : cur[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cl_ocl_cycle_cnt.sv
// ---------------------------------------------------------------------------
// cl_ocl_cycle_cnt
// Free-running 64-bit cycle counter with a high-word snapshot.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clears counter and snapshot (wins over snap)
//   snap       : captures count[63:32] so a later high-word read is coherent
//                with the low word read on the same edge
//   count      : current count (wraps 2^64-1 -> 0)
//   snap_hi    : captured high word
// ---------------------------------------------------------------------------
module cl_ocl_cycle_cnt
    import cl_ocl_axil_regs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      snap_hi
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            snap_hi <= '0;
        end else if (clr) begin
            count   <= '0;
            snap_hi <= '0;
        end else begin
            count <= count + 1'b1;
            if (snap) begin
                snap_hi <= count[63:32];
            end
        end
    end

endmodule

// File: rtl/cl_ocl_axil_regs.sv
// ---------------------------------------------------------------------------
// cl_ocl_axil_regs
// AXI-Lite slave register file on the OCL BAR0 path. One outstanding write
// and one outstanding read; the two channels run independently.
//   clk_main_a0, rst_main_n           : clock, asynchronous active-low reset
//   aw*/w*/b*                         : AXI-Lite write address/data/response
//   ar*/r*                            : AXI-Lite read address/data
//   cl_sh_status_vled                 : VLED[15:0] to the shell
// Registers: 0x500 HELLO_WORLD (read halfword-swapped), 0x504 VLED[15:0],
// 0x510 SCRATCH. Unmapped: write ignored + SLVERR, read DEAD_BEEF + SLVERR.
// Optional feature macro CL_OCL_REGS_CYCLE_CNT_EN adds a 64-bit cycle
// counter at 0x508 (CNT_LO, snapshots high word) / 0x50C (CNT_HI).
// ---------------------------------------------------------------------------
module cl_ocl_axil_regs
    import cl_ocl_axil_regs_pkg::*;
(
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [15:0] cl_sh_status_vled
);

    // Held low during reset and for the first edge after release, so the
    // ready outputs only come up on the first clock after reset.
    logic        ready_en;

    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;

    logic        aw_done, w_done;
    logic [29:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        wr_fire;
    logic [29:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic [31:0] hello_q;
    logic [15:0] vled_q;
    logic [31:0] scratch_q;

    logic [31:0] rd_data_mux;
    logic [1:0]  rd_resp_mux;

    logic        unused_bits;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // The write commits on the edge where the second of AW/W is captured;
    // whichever arrived earlier comes from its holding register.
    assign wr_fire = (wr_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
    assign wr_addr = aw_done ? aw_addr_q : awaddr[31:2];
    assign wr_data = w_done  ? w_data_q  : wdata;
    assign wr_strb = w_done  ? w_strb_q  : wstrb;

    assign cl_sh_status_vled = vled_q;

`ifdef CL_OCL_REGS_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_count;
    logic [31:0]      cnt_snap_hi;
    logic             cnt_clr, cnt_snap;

    assign cnt_clr  = wr_fire && ((wr_addr == CNT_LO[31:2]) || (wr_addr == CNT_HI[31:2]));
    assign cnt_snap = ar_hs && (araddr[31:2] == CNT_LO[31:2]);

    cl_ocl_cycle_cnt u_cycle_cnt (
        .clk     (clk_main_a0),
        .rst_n   (rst_main_n),
        .clr     (cnt_clr),
        .snap    (cnt_snap),
        .count   (cnt_count),
        .snap_hi (cnt_snap_hi)
    );

    assign unused_bits = ^{awaddr[1:0], araddr[1:0], cnt_count[63:32]};
`else
    assign unused_bits = ^{awaddr[1:0], araddr[1:0]};
`endif

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // ---------------- write channel FSM ----------------
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE: if (wr_fire) wr_next = W_RESP;
            W_RESP: if (bready)  wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = ready_en && !aw_done;
                wready  = ready_en && !w_done;
            end
            W_RESP: bvalid = 1'b1;
            default: ;
        endcase
    end

    // Per-channel capture; flags stay set through W_RESP and clear on B.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (b_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done   <= 1'b1;
                aw_addr_q <= awaddr[31:2];
            end
            if (w_hs) begin
                w_done   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    // Register file update and write response.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            hello_q   <= '0;
            vled_q    <= '0;
            scratch_q <= '0;
            bresp     <= OKAY;
        end else if (wr_fire) begin
            case (wr_addr)
                HELLO_WORLD[31:2]: begin
                    hello_q <= apply_strb(hello_q, wr_data, wr_strb);
                    bresp   <= OKAY;
                end
                VLED[31:2]: begin
                    vled_q <= {wr_strb[1] ? wr_data[15:8] : vled_q[15:8],
                               wr_strb[0] ? wr_data[7:0]  : vled_q[7:0]};
                    bresp  <= OKAY;
                end
                SCRATCH[31:2]: begin
                    scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
                    bresp     <= OKAY;
                end
`ifdef CL_OCL_REGS_CYCLE_CNT_EN
                CNT_LO[31:2], CNT_HI[31:2]: bresp <= OKAY;
`endif
                default: bresp <= SLVERR;
            endcase
        end
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE: if (ar_hs) rd_next = R_DATA;
            R_DATA: if (r_hs)  rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: arready = ready_en;
            R_DATA: rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read mux sees pre-edge register values, so a read landing on the same
    // edge as a write to that register returns the old contents.
    always_comb begin
        rd_data_mux = DEAD_BEEF;
        rd_resp_mux = SLVERR;
        case (araddr[31:2])
            HELLO_WORLD[31:2]: begin
                rd_data_mux = {hello_q[15:0], hello_q[31:16]};
                rd_resp_mux = OKAY;
            end
            VLED[31:2]: begin
                rd_data_mux = {16'h0000, vled_q};
                rd_resp_mux = OKAY;
            end
            SCRATCH[31:2]: begin
                rd_data_mux = scratch_q;
                rd_resp_mux = OKAY;
            end
`ifdef CL_OCL_REGS_CYCLE_CNT_EN
            CNT_LO[31:2]: begin
                rd_data_mux = cnt_count[31:0];
                rd_resp_mux = OKAY;
            end
            CNT_HI[31:2]: begin
                rd_data_mux = cnt_snap_hi;
                rd_resp_mux = OKAY;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rdata <= '0;
            rresp <= OKAY;
        end else if (ar_hs) begin
            rdata <= rd_data_mux;
            rresp <= rd_resp_mux;
        end
    end

endmodule
